// File: rtl/immu_itlb_refill.sv
// Instruction-side TLB miss service: queries the UTLB on an IMMU miss, refills one shadow-ITLB
// entry round-robin on a hit and replays the fetch, or raises the ITLB-miss exception.
module immu_itlb_refill #(
  parameter int ITLB_ENTRIES = 4,
  parameter int IDX_W        = 2,
  parameter int TIMEOUT      = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Miss,
  input  logic [31:0]      EA,
  input  logic             MSR_IS,
  input  logic [7:0]       PID0,
  input  logic [7:0]       PID1,
  input  logic [7:0]       PID2,
  input  logic             flush,
  output logic             utlb_req,
  output logic [19:0]      utlb_epn,
  output logic             utlb_as,
  input  logic             utlb_ack,
  input  logic             utlb_hit,
  input  logic [7:0]       utlb_tid,
  input  logic [19:0]      utlb_rpn,
  input  logic [5:0]       utlb_permis,
  output logic             itlb_we,
  output logic [IDX_W-1:0] itlb_idx,
  output logic [55:0]      itlb_wdata,
  output logic             fetch_stall,
  output logic             replay,
  output logic             itlb_miss_exc,
  output logic [31:0]      exc_ea
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FILL,
    S_DONE,
    S_EXC
  } state_t;

  state_t           state_reg, state_next;
  logic [31:0]      ea_reg;
  logic             as_reg;
  logic [23:0]      pid_reg;
  logic [7:0]       tid_reg;
  logic [19:0]      rpn_reg;
  logic [5:0]       permis_reg;
  logic [IDX_W-1:0] victim_reg;
  logic [7:0]       cnt_reg;
  logic [31:0]      exc_ea_reg;
  logic             take_resp;

  always_comb begin
    state_next    = state_reg;
    fetch_stall   = 1'b0;
    utlb_req      = 1'b0;
    itlb_we       = 1'b0;
    replay        = 1'b0;
    itlb_miss_exc = 1'b0;
    take_resp     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        // Stall in the miss cycle itself; gated by rst so reset really forces all outputs low.
        if (rst && Miss && !flush) begin
          fetch_stall = 1'b1;
          state_next  = S_REQ;
        end
      end
      S_REQ, S_WAIT: begin
        utlb_req    = 1'b1;
        fetch_stall = 1'b1;
        if (flush) begin
          state_next = S_IDLE;
        end else if (utlb_ack) begin
          take_resp  = 1'b1;
          state_next = utlb_hit ? S_FILL : S_EXC;
        end else if (state_reg == S_REQ) begin
          state_next = S_WAIT;
        end else if (cnt_reg + 8'd1 == TIMEOUT_CNT) begin
          state_next = S_EXC;
        end
      end
      S_FILL: begin
        fetch_stall = 1'b1;
        if (flush) begin
          state_next = S_IDLE;
        end else begin
          itlb_we    = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        replay     = 1'b1;
        state_next = S_IDLE;
      end
      S_EXC: begin
        fetch_stall   = 1'b1;
        itlb_miss_exc = 1'b1;
        state_next    = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= S_IDLE;
      ea_reg     <= '0;
      as_reg     <= 1'b0;
      pid_reg    <= '0;
      tid_reg    <= '0;
      rpn_reg    <= '0;
      permis_reg <= '0;
      victim_reg <= '0;
      cnt_reg    <= '0;
      exc_ea_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IDLE && state_next == S_REQ) begin
        ea_reg  <= EA;
        as_reg  <= MSR_IS;
        pid_reg <= {PID2, PID1, PID0};
      end
      if (take_resp) begin
        tid_reg    <= utlb_tid;
        rpn_reg    <= utlb_rpn;
        permis_reg <= utlb_permis;
      end
      // Power-of-two entry count: natural overflow gives the wrap to entry 0.
      if (itlb_we) victim_reg <= victim_reg + 1'b1;
      if (state_reg == S_WAIT && state_next == S_WAIT) cnt_reg <= cnt_reg + 8'd1;
      else cnt_reg <= '0;
      if (state_next == S_EXC && state_reg != S_EXC) exc_ea_reg <= ea_reg;
    end
  end

  assign utlb_epn   = ea_reg[31:12];
  assign utlb_as    = as_reg;
  assign itlb_idx   = victim_reg;
  assign itlb_wdata = itlb_we ? {1'b1, as_reg, tid_reg, ea_reg[31:12], rpn_reg, permis_reg} : 56'd0;
  assign exc_ea     = exc_ea_reg;

endmodule
